// File: rtl/alu_wb_buffer_pkg.sv
// Shared types and widths for the ALU write-back buffer.
//   XLEN            datapath width of ALU results
//   TRANS_ID_BITS   scoreboard transaction ID width
//   alu_wb_entry_t  one held ALU result {trans_id, result, branch_res}
package alu_wb_buffer_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     branch_res;
    } alu_wb_entry_t;

endpackage

// File: rtl/alu_wb_buffer.sv
// In-order FIFO between the ALU and the scoreboard write-back port.
// Captures each ALU result and presents the oldest one with valid/ready,
// so ALU issue is decoupled from stalls on a shared write-back port.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous flush, drops all held entries
//   alu_valid_i/ready_o    push handshake (ready = not full)
//   alu_trans_id_i, alu_result_i, alu_branch_res_i   incoming entry
//   wb_valid_o/ready_i     pop handshake for the head entry
//   wb_trans_id_o, wb_result_o, wb_branch_res_o      head entry, 0 when empty
//   occupancy_o            number of entries held (0..DEPTH)
module alu_wb_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_i,
    input  logic                                        alu_valid_i,
    output logic                                        alu_ready_o,
    input  logic [alu_wb_buffer_pkg::TRANS_ID_BITS-1:0] alu_trans_id_i,
    input  logic [alu_wb_buffer_pkg::XLEN-1:0]          alu_result_i,
    input  logic                                        alu_branch_res_i,
    output logic                                        wb_valid_o,
    input  logic                                        wb_ready_i,
    output logic [alu_wb_buffer_pkg::TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [alu_wb_buffer_pkg::XLEN-1:0]          wb_result_o,
    output logic                                        wb_branch_res_o,
    output logic [$clog2(DEPTH):0]                      occupancy_o
);
    import alu_wb_buffer_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    alu_wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic                 push, pop;
    alu_wb_entry_t        head;

    // Handshake status comes from registered state only; ready never looks at wb_ready_i.
    assign alu_ready_o = (count_q != CNT_W'(DEPTH));
    assign wb_valid_o  = (count_q != '0);
    assign occupancy_o = count_q;

    assign push = alu_valid_i & alu_ready_o;
    assign pop  = wb_valid_o & wb_ready_i;

    // Head entry, forced to zero while empty so stale storage never leaks out.
    assign head            = mem_q[rd_ptr_q];
    assign wb_trans_id_o   = wb_valid_o ? head.trans_id   : '0;
    assign wb_result_o     = wb_valid_o ? head.result     : '0;
    assign wb_branch_res_o = wb_valid_o ? head.branch_res : 1'b0;

    // Next-state for pointers and count; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= '{trans_id:   alu_trans_id_i,
                                 result:     alu_result_i,
                                 branch_res: alu_branch_res_i};
        end
    end

`ifndef SYNTHESIS
    // A push into a full buffer is dropped; report it so the producer bug is visible.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && alu_valid_i) begin
            assert (alu_ready_o)
            else $warning("alu_wb_buffer: push while full, entry dropped");
        end
    end
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
module tb_alu_wb_buffer;
    import alu_wb_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst_ni;
    logic                     flush_i;
    logic                     alu_valid_i;
    logic                     alu_ready_o;
    logic [TRANS_ID_BITS-1:0] alu_trans_id_i;
    logic [XLEN-1:0]          alu_result_i;
    logic                     alu_branch_res_i;
    logic                     wb_valid_o;
    logic                     wb_ready_i;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic [XLEN-1:0]          wb_result_o;
    logic                     wb_branch_res_o;
    logic [$clog2(DEPTH):0]   occupancy_o;

    int unsigned   n_checks = 0;
    int unsigned   n_passed = 0;
    alu_wb_entry_t sb_q[$];

    always #5 clk = ~clk;

    alu_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .alu_valid_i      (alu_valid_i),
        .alu_ready_o      (alu_ready_o),
        .alu_trans_id_i   (alu_trans_id_i),
        .alu_result_i     (alu_result_i),
        .alu_branch_res_i (alu_branch_res_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_trans_id_o    (wb_trans_id_o),
        .wb_result_o      (wb_result_o),
        .wb_branch_res_o  (wb_branch_res_o),
        .occupancy_o      (occupancy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard at
    // the falling edge, then advance the scoreboard by what the edge will do.
    task automatic cycle(input logic v, input logic [TRANS_ID_BITS-1:0] id,
                         input logic [63:0] res, input logic br,
                         input logic rdy, input logic fl);
        alu_wb_entry_t e;
        logic          can_push;
        logic          can_pop;
        alu_valid_i      = v;
        alu_trans_id_i   = id;
        alu_result_i     = res;
        alu_branch_res_i = br;
        wb_ready_i       = rdy;
        flush_i          = fl;
        @(negedge clk);
        chk("occupancy", 64'(occupancy_o), 64'(sb_q.size()));
        chk("alu_ready", 64'(alu_ready_o), 64'(sb_q.size() != DEPTH));
        chk("wb_valid",  64'(wb_valid_o),  64'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("wb_trans_id", 64'(wb_trans_id_o),   64'(sb_q[0].trans_id));
            chk("wb_result",   64'(wb_result_o),     64'(sb_q[0].result));
            chk("wb_branch",   64'(wb_branch_res_o), 64'(sb_q[0].branch_res));
        end else begin
            chk("wb_trans_id_empty", 64'(wb_trans_id_o),   64'd0);
            chk("wb_result_empty",   64'(wb_result_o),     64'd0);
            chk("wb_branch_empty",   64'(wb_branch_res_o), 64'd0);
        end
        can_push = v && (sb_q.size() != DEPTH);
        can_pop  = rdy && (sb_q.size() != 0);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (can_pop) void'(sb_q.pop_front());
            if (can_push) begin
                e.trans_id   = id;
                e.result     = res;
                e.branch_res = br;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [TRANS_ID_BITS-1:0] id, input logic rdy);
        cycle(1'b1, id, {$urandom, $urandom}, 1'($urandom), rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, '0, 64'd0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        rst_ni           = 1'b0;
        flush_i          = 1'b0;
        alu_valid_i      = 1'b0;
        alu_trans_id_i   = '0;
        alu_result_i     = '0;
        alu_branch_res_i = 1'b0;
        wb_ready_i       = 1'b0;

        // Power-on reset state
        #2;
        chk("rst_wb_valid",  64'(wb_valid_o),  64'd0);
        chk("rst_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("rst_occupancy", 64'(occupancy_o), 64'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Single pass-through
        cycle(1'b1, 3'd5, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Fill with backpressure, then drain in order
        for (int i = 1; i <= 4; i++) push_one(TRANS_ID_BITS'(i), 1'b0);
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Wrap: hold two entries, then push+pop every cycle across the wrap
        push_one(3'd1, 1'b0);
        push_one(3'd2, 1'b0);
        for (int i = 3; i <= 8; i++) push_one(TRANS_ID_BITS'(i), 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush with a same-cycle push and pop
        for (int i = 0; i < 3; i++) push_one(TRANS_ID_BITS'(i + 4), 1'b0);
        cycle(1'b1, 3'd7, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Full + same-cycle pop: pop happens, push is rejected
        for (int i = 0; i < 4; i++) push_one(TRANS_ID_BITS'(i), 1'b0);
        cycle(1'b1, 3'd6, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Asynchronous reset mid-stream with three entries held
        for (int i = 0; i < 3; i++) push_one(TRANS_ID_BITS'(i + 1), 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("midrst_wb_valid",  64'(wb_valid_o),  64'd0);
        chk("midrst_occupancy", 64'(occupancy_o), 64'd0);
        chk("midrst_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("midrst_wb_result", 64'(wb_result_o), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        idle(1'b1);
        push_one(3'd3, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
